// File: rtl/gyn_wb_arbiter.sv
// Write-back arbiter: merges ALU and load results onto one shared regfile write port,
// buffers loads that lose arbitration and tracks pending loads. Optional forwarding: GYN_WB_BYPASS_EN.
module gyn_wb_arbiter #(
  parameter int NTHREADS   = 4,
  parameter int TID_W      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          alu_valid,
  input  logic [TID_W-1:0]              alu_tid,
  input  logic [3:0]                    alu_rd,
  input  logic [71:0]                   alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [TID_W-1:0]              mem_tid,
  input  logic [3:0]                    mem_rd,
  input  logic [71:0]                   mem_data,
  input  logic                          ld_issue,
  input  logic [TID_W-1:0]              ld_tid,
  input  logic [3:0]                    ld_rd,
  input  logic [TID_W-1:0]              q_tid,
  input  logic [3:0]                    q_r0addr,
  input  logic [3:0]                    q_r1addr,
  output logic                          q_r0busy,
  output logic                          q_r1busy,
  output logic [NTHREADS-1:0]           wena,
  output logic [3:0]                    waddr,
  output logic [71:0]                   wdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          err_addr
`ifdef GYN_WB_BYPASS_EN
  ,
  output logic                          q_r0fwd,
  output logic                          q_r1fwd,
  output logic [71:0]                   q_fwd_data,
  output logic [71:0]                   q_fwd1_data
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TID_W-1:0]    r_fifoTid  [FIFO_DEPTH];
  logic [3:0]          r_fifoRd   [FIFO_DEPTH];
  logic [71:0]         r_fifoData [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wrPtr;
  logic [PTR_W-1:0]    r_rdPtr;
  logic [CNT_W-1:0]    r_fifoCnt;
  logic [NTHREADS-1:0] r_wena;
  logic [3:0]          r_waddr;
  logic [71:0]         r_wdata;
  logic                r_wMem;
  logic                r_err;
  logic [7:0]          r_busy [NTHREADS];

  logic                w_memAcc;
  logic                w_push;
  logic                w_pop;
  logic                w_winValid;
  logic                w_winMem;
  logic                w_winLegal;
  logic [TID_W-1:0]    w_winTid;
  logic [3:0]          w_winRd;
  logic [71:0]         w_winData;
  logic [NTHREADS-1:0] w_wenaNext;

  // Ready comes from the registered count only, so a full buffer refuses even while popping.
  assign mem_ready = (r_fifoCnt < CNT_W'(FIFO_DEPTH));

  always_comb begin
    w_memAcc   = mem_valid && mem_ready;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_winValid = 1'b0;
    w_winMem   = 1'b0;
    w_winTid   = alu_tid;
    w_winRd    = alu_rd;
    w_winData  = alu_data;
    if (alu_valid) begin
      w_winValid = 1'b1;
      w_push     = w_memAcc;
    end else if (r_fifoCnt != '0) begin
      w_winValid = 1'b1;
      w_winMem   = 1'b1;
      w_winTid   = r_fifoTid[r_rdPtr];
      w_winRd    = r_fifoRd[r_rdPtr];
      w_winData  = r_fifoData[r_rdPtr];
      w_pop      = 1'b1;
      w_push     = w_memAcc;
    end else if (w_memAcc) begin
      w_winValid = 1'b1;
      w_winMem   = 1'b1;
      w_winTid   = mem_tid;
      w_winRd    = mem_rd;
      w_winData  = mem_data;
    end
    w_winLegal = w_winValid && (w_winRd != 4'd0) && !w_winRd[3];
    w_wenaNext = '0;
    if (w_winLegal) w_wenaNext[w_winTid] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifoTid[r_wrPtr]  <= mem_tid;
      r_fifoRd[r_wrPtr]   <= mem_rd;
      r_fifoData[r_wrPtr] <= mem_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_fifoCnt <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_fifoCnt <= r_fifoCnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wena  <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wMem  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wena <= w_wenaNext;
      r_wMem <= w_winMem && w_winLegal;
      if (w_winValid) begin
        r_waddr <= w_winRd;
        r_wdata <= w_winData;
      end
      if ((w_winValid && w_winRd[3]) || (ld_issue && ld_rd[3])) r_err <= 1'b1;
    end
  end

  // Clear lands on the same edge the regfile captures the load; a new issue overrides it.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int t = 0; t < NTHREADS; t++) r_busy[t] <= '0;
    end else begin
      for (int t = 0; t < NTHREADS; t++) begin
        for (int r = 1; r < 8; r++) begin
          if (ld_issue && (ld_tid == TID_W'(t)) && (ld_rd == 4'(r)))
            r_busy[t][r] <= 1'b1;
          else if (r_wMem && r_wena[t] && (r_waddr == 4'(r)))
            r_busy[t][r] <= 1'b0;
        end
      end
    end
  end

  assign q_r0busy = !q_r0addr[3] && r_busy[q_tid][q_r0addr[2:0]];
  assign q_r1busy = !q_r1addr[3] && r_busy[q_tid][q_r1addr[2:0]];
  assign wena     = r_wena;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign fifo_cnt = r_fifoCnt;
  assign err_addr = r_err;

`ifdef GYN_WB_BYPASS_EN
  assign q_r0fwd     = r_wena[q_tid] && (r_waddr == q_r0addr) && (q_r0addr != 4'd0);
  assign q_r1fwd     = r_wena[q_tid] && (r_waddr == q_r1addr) && (q_r1addr != 4'd0);
  assign q_fwd_data  = r_wdata;
  assign q_fwd1_data = r_wdata;
`endif

endmodule

// File: tb/tb_gyn_wb_arbiter.sv
// Self-checking bench for gyn_wb_arbiter: directed vector table, hand sequences for
// back-pressure / scoreboard / reset, then random traffic against a queue-based model.
module tb_gyn_wb_arbiter;
  localparam int NT = 4;
  localparam int FD = 4;

  typedef struct {
    logic [1:0]  tid;
    logic [3:0]  rd;
    logic [71:0] data;
  } beat_t;

  typedef struct {
    logic        aluValid;
    logic [1:0]  aluTid;
    logic [3:0]  aluRd;
    logic [71:0] aluData;
    logic        memValid;
    logic [1:0]  memTid;
    logic [3:0]  memRd;
    logic [71:0] memData;
    logic [3:0]  expWena;
    logic [3:0]  expWaddr;
    logic [71:0] expWdata;
    int          expCnt;
  } vec_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        reset;
  logic        alu_valid, mem_valid, mem_ready, ld_issue;
  logic [1:0]  alu_tid, mem_tid, ld_tid, q_tid;
  logic [3:0]  alu_rd, mem_rd, ld_rd, q_r0addr, q_r1addr;
  logic [71:0] alu_data, mem_data;
  logic        q_r0busy, q_r1busy;
  logic [3:0]  wena;
  logic [3:0]  waddr;
  logic [71:0] wdata;
  logic [2:0]  fifo_cnt;
  logic        err_addr;
`ifdef GYN_WB_BYPASS_EN
  logic        q_r0fwd, q_r1fwd;
  logic [71:0] q_fwd_data, q_fwd1_data;
`endif

  gyn_wb_arbiter #(.NTHREADS(NT), .TID_W(2), .FIFO_DEPTH(FD)) dut (
    .CLK(CLK), .reset(reset),
    .alu_valid(alu_valid), .alu_tid(alu_tid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_tid(mem_tid), .mem_rd(mem_rd),
    .mem_data(mem_data),
    .ld_issue(ld_issue), .ld_tid(ld_tid), .ld_rd(ld_rd),
    .q_tid(q_tid), .q_r0addr(q_r0addr), .q_r1addr(q_r1addr),
    .q_r0busy(q_r0busy), .q_r1busy(q_r1busy),
    .wena(wena), .waddr(waddr), .wdata(wdata), .fifo_cnt(fifo_cnt), .err_addr(err_addr)
`ifdef GYN_WB_BYPASS_EN
    ,
    .q_r0fwd(q_r0fwd), .q_r1fwd(q_r1fwd), .q_fwd_data(q_fwd_data), .q_fwd1_data(q_fwd1_data)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending loads as a queue, scoreboard as bit array, last write.
  beat_t       mq[$];
  bit [7:0]    mBusy [NT];
  logic [3:0]  mWena;
  logic [3:0]  mWaddr;
  logic [71:0] mWdata;
  bit          mWMem;
  bit          mErr;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit legalRd(input logic [3:0] rd);
    return (rd != 4'd0) && (rd < 4'd8);
  endfunction

  function automatic bit expBusy(input logic [1:0] t, input logic [3:0] a);
    if (!legalRd(a)) return 1'b0;
    return mBusy[t][a[2:0]];
  endfunction

  task automatic modelReset();
    mq.delete();
    for (int t = 0; t < NT; t++) mBusy[t] = '0;
    mWena = '0; mWaddr = '0; mWdata = '0; mWMem = 0; mErr = 0;
  endtask

  task automatic idleInputs();
    alu_valid = 0; alu_tid = 0; alu_rd = 0; alu_data = '0;
    mem_valid = 0; mem_tid = 0; mem_rd = 0; mem_data = '0;
    ld_issue = 0; ld_tid = 0; ld_rd = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    alu_valid = v.aluValid; alu_tid = v.aluTid; alu_rd = v.aluRd; alu_data = v.aluData;
    mem_valid = v.memValid; mem_tid = v.memTid; mem_rd = v.memRd; mem_data = v.memData;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic stepCycle();
    beat_t w;
    bit haveWin, fromMem;
    bit [7:0] nb [NT];
    #1;
    checkOutput("mem_ready", mem_ready, mq.size() < FD);
    checkOutput("q_r0busy", q_r0busy, expBusy(q_tid, q_r0addr));
    checkOutput("q_r1busy", q_r1busy, expBusy(q_tid, q_r1addr));
`ifdef GYN_WB_BYPASS_EN
    checkOutput("q_r0fwd", q_r0fwd, mWena[q_tid] && (mWaddr == q_r0addr) && (q_r0addr != 0));
    checkOutput("q_r1fwd", q_r1fwd, mWena[q_tid] && (mWaddr == q_r1addr) && (q_r1addr != 0));
    if (q_r0fwd) checkOutput("q_fwd_data", q_fwd_data, mWdata);
    if (q_r1fwd) checkOutput("q_fwd1_data", q_fwd1_data, mWdata);
`endif
    if (reset) begin
      modelReset();
    end else begin
      nb = mBusy;
      if (mWMem)
        for (int t = 0; t < NT; t++) if (mWena[t]) nb[t][mWaddr[2:0]] = 1'b0;
      if (ld_issue && legalRd(ld_rd)) nb[ld_tid][ld_rd[2:0]] = 1'b1;
      if (ld_issue && ld_rd >= 4'd8) mErr = 1;
      mBusy = nb;
      if (mem_valid && mq.size() < FD) mq.push_back('{mem_tid, mem_rd, mem_data});
      haveWin = 0; fromMem = 0;
      if (alu_valid) begin
        haveWin = 1; w = '{alu_tid, alu_rd, alu_data};
      end else if (mq.size() > 0) begin
        haveWin = 1; fromMem = 1; w = mq.pop_front();
      end
      mWena = '0; mWMem = 0;
      if (haveWin) begin
        mWaddr = w.rd; mWdata = w.data; mWMem = fromMem;
        if (legalRd(w.rd)) mWena[w.tid] = 1'b1;
        if (w.rd >= 4'd8) mErr = 1;
      end
    end
    @(posedge CLK);
    #1;
    checkOutput("wena", wena, mWena);
    if (mWena != 0) begin
      checkOutput("waddr", waddr, mWaddr);
      checkOutput("wdata", wdata, mWdata);
    end
    checkOutput("fifo_cnt", fifo_cnt, mq.size());
    checkOutput("err_addr", err_addr, mErr);
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd2, 4'd5, 72'hA5, 1'b0, 2'd0, 4'd0, 72'h0,  4'b0100, 4'd5, 72'hA5, 0};
    vecs[1] = '{1'b0, 2'd0, 4'd0, 72'h0,  1'b0, 2'd0, 4'd0, 72'h0,  4'b0000, 4'd0, 72'h0,  0};
    vecs[2] = '{1'b1, 2'd0, 4'd1, 72'h1,  1'b1, 2'd1, 4'd3, 72'h2,  4'b0001, 4'd1, 72'h1,  1};
    vecs[3] = '{1'b0, 2'd0, 4'd0, 72'h0,  1'b0, 2'd0, 4'd0, 72'h0,  4'b0010, 4'd3, 72'h2,  0};
    vecs[4] = '{1'b0, 2'd0, 4'd0, 72'h0,  1'b0, 2'd0, 4'd0, 72'h0,  4'b0000, 4'd0, 72'h0,  0};
    vecs[5] = '{1'b0, 2'd0, 4'd0, 72'h0,  1'b1, 2'd2, 4'd4, 72'h33, 4'b0100, 4'd4, 72'h33, 0};
    vecs[6] = '{1'b1, 2'd1, 4'd0, 72'h7,  1'b0, 2'd0, 4'd0, 72'h0,  4'b0000, 4'd0, 72'h0,  0};
    vecs[7] = '{1'b0, 2'd0, 4'd0, 72'h0,  1'b0, 2'd0, 4'd0, 72'h0,  4'b0000, 4'd0, 72'h0,  0};

    idleInputs();
    q_tid = 0; q_r0addr = 0; q_r1addr = 0;
    reset = 1;
    repeat (2) @(posedge CLK);
    #1;
    reset = 0;
    modelReset();
    checkOutput("rst_wena", wena, 4'b0);
    checkOutput("rst_waddr", waddr, 4'd0);
    checkOutput("rst_wdata", wdata, 72'h0);
    checkOutput("rst_fifo_cnt", fifo_cnt, 3'd0);
    checkOutput("rst_err", err_addr, 1'b0);
    checkOutput("rst_mem_ready", mem_ready, 1'b1);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      stepCycle();
      checkOutput($sformatf("vec%0d_wena", i), wena, vecs[i].expWena);
      if (vecs[i].expWena != 0) begin
        checkOutput($sformatf("vec%0d_waddr", i), waddr, vecs[i].expWaddr);
        checkOutput($sformatf("vec%0d_wdata", i), wdata, vecs[i].expWdata);
      end
      checkOutput($sformatf("vec%0d_cnt", i), fifo_cnt, 3'(vecs[i].expCnt));
    end
    idleInputs();
    checkOutput("err_after_rd0", err_addr, 1'b0);

    // Back-pressure: ALU hogs the port while loads pile up, then drain in order
    alu_valid = 1; alu_tid = 0; alu_rd = 2; alu_data = 72'h55;
    for (int i = 0; i < 6; i++) begin
      mem_valid = 1; mem_tid = 1; mem_rd = 4'(i + 1); mem_data = 72'h100 + 72'(i);
      stepCycle();
    end
    checkOutput("bp_full_cnt", fifo_cnt, 3'd4);
    checkOutput("bp_not_ready", mem_ready, 1'b0);
    idleInputs();
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput($sformatf("drain%0d_waddr", i), waddr, 4'(i + 1));
      checkOutput($sformatf("drain%0d_wdata", i), wdata, 72'h100 + 72'(i));
    end
    checkOutput("bp_ready_again", mem_ready, 1'b1);

    // Scoreboard: plain clear on r6, reissue in the landing cycle on r7
    q_tid = 3; q_r0addr = 7; q_r1addr = 6;
    ld_issue = 1; ld_tid = 3; ld_rd = 6;
    stepCycle();
    ld_rd = 7;
    stepCycle();
    ld_issue = 0;
    checkOutput("sb_r7_busy", q_r0busy, 1'b1);
    mem_valid = 1; mem_tid = 3; mem_rd = 6; mem_data = 72'h66;
    stepCycle();
    checkOutput("sb_r6_busy_landing", q_r1busy, 1'b1);
    mem_rd = 7; mem_data = 72'h77;
    stepCycle();
    checkOutput("sb_r6_cleared", q_r1busy, 1'b0);
    checkOutput("sb_r7_busy_landing", q_r0busy, 1'b1);
    mem_valid = 0;
    ld_issue = 1; ld_tid = 3; ld_rd = 7;
    stepCycle();
    ld_issue = 0;
    checkOutput("sb_r7_set_wins", q_r0busy, 1'b1);

    // Illegal address: rd=9 load is swallowed and flags err_addr stickily
    mem_valid = 1; mem_tid = 0; mem_rd = 9; mem_data = 72'h99;
    stepCycle();
    mem_valid = 0;
    checkOutput("ill_wena", wena, 4'b0);
    checkOutput("ill_err", err_addr, 1'b1);
    repeat (3) stepCycle();
    checkOutput("ill_err_sticky", err_addr, 1'b1);

    // Reset while loads are buffered and busy bits are set
    ld_issue = 1; ld_tid = 2; ld_rd = 2;
    stepCycle();
    ld_issue = 0;
    alu_valid = 1; alu_tid = 1; alu_rd = 1; alu_data = 72'hAA;
    mem_valid = 1; mem_tid = 2; mem_rd = 3;
    for (int i = 0; i < 3; i++) begin
      mem_data = 72'h200 + 72'(i);
      stepCycle();
    end
    checkOutput("rd_pre_cnt", fifo_cnt, 3'd3);
    q_tid = 2; q_r0addr = 2; q_r1addr = 3;
    reset = 1;
    stepCycle();
    reset = 0;
    idleInputs();
    checkOutput("rd_cnt", fifo_cnt, 3'd0);
    checkOutput("rd_wena", wena, 4'b0);
    checkOutput("rd_busy", q_r0busy, 1'b0);
    checkOutput("rd_err", err_addr, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      reset     = ($urandom_range(0, 149) == 0);
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_tid   = 2'($urandom);
      alu_rd    = 4'($urandom_range(0, 8));
      alu_data  = {8'($urandom), 32'($urandom), 32'($urandom)};
      mem_valid = ($urandom_range(0, 1) == 0);
      mem_tid   = 2'($urandom);
      mem_rd    = ($urandom_range(0, 40) == 0) ? 4'd12 : 4'($urandom_range(0, 7));
      mem_data  = {8'($urandom), 32'($urandom), 32'($urandom)};
      ld_issue  = ($urandom_range(0, 1) == 0);
      ld_tid    = 2'($urandom);
      ld_rd     = ($urandom_range(0, 60) == 0) ? 4'd8 : 4'($urandom_range(0, 7));
      q_tid     = 2'($urandom);
      q_r0addr  = 4'($urandom_range(0, 8));
      q_r1addr  = 4'($urandom_range(0, 8));
      stepCycle();
    end
    reset = 0;
    idleInputs();
    repeat (6) stepCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gyn_wb_arbiter.md
Name: gyn_wb_arbiter

Overview:
- Write-back side of the per-thread register files (8 x 72-bit per thread, R0 hard zero).
- Merges ALU results and memory-load results into one shared write bus: wena one-hot per thread, waddr, wdata.
- Buffers loads that lose arbitration.
- Keeps a per-thread pending-load scoreboard so decode can stall on registers whose loads have not landed yet.

Parameters:
- NTHREADS, 4, number of hardware threads / register files.
- TID_W, 2, thread-id width; must equal clog2(NTHREADS).
- FIFO_DEPTH, 4, load-result buffer entries (power of 2, >=2).

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU result present; always accepted, no ready
- alu_tid  in  TID_W  ALU result thread
- alu_rd  in  4  ALU destination register
- alu_data  in  72  ALU result
- mem_valid  in  1  load result present
- mem_ready  out  1  load result accepted when mem_valid & mem_ready
- mem_tid  in  TID_W  load thread
- mem_rd  in  4  load destination
- mem_data  in  72  load data
- ld_issue  in  1  load issued this cycle; marks the destination busy
- ld_tid  in  TID_W  issuing thread
- ld_rd  in  4  issuing destination
- q_tid  in  TID_W  decode query thread
- q_r0addr  in  4  query source 0
- q_r1addr  in  4  query source 1
- q_r0busy  out  1  source 0 has a pending load
- q_r1busy  out  1  source 1 has a pending load
- wena  out  NTHREADS  one-hot regfile write enable, registered
- waddr  out  4  write address, registered
- wdata  out  72  write data, registered
- fifo_cnt  out  clog2(FIFO_DEPTH)+1  buffered load entries
- err_addr  out  1  sticky: write or issue with address >= 8 seen

Behaviour:
- Reset, synchronous: wena=0, waddr=0, wdata=0, FIFO empty, fifo_cnt=0, all busy bits 0, err_addr=0.
- mem_ready = (fifo_cnt < FIFO_DEPTH), taken from the registered count. A full FIFO is not ready even in a pop cycle.
- Arbitration each cycle, one write maximum. Priority order:
  - alu_valid;
  - else FIFO head;
  - else the accepted mem beat directly (FIFO bypass).
- Any accepted mem beat that is not written directly is pushed. Order of load results is preserved.
- Latency: the winner appears on wena/waddr/wdata at the next edge and is held for exactly one cycle. wena=0 when nothing wins.
- wena[tid]=1 only for rd in 1..7.
  - rd=0: consumes its slot, wena stays 0.
  - rd>=8: consumes its slot, wena stays 0, err_addr set.
- Scoreboard busy[t][r], r in 1..7:
  - Set on ld_issue for (ld_tid, ld_rd).
  - Cleared in the cycle wena is high for a mem-sourced write to (t, r). That is the same edge the regfile captures the data, so a query never sees not-busy with stale regfile contents.
  - Set and clear of the same (t, r) in one cycle: set wins.
  - ld_issue with rd=0 is ignored. ld_issue with rd>=8 sets err_addr.
- q_rNbusy = busy[q_tid][q_rNaddr], combinational. Address 0 or >=8 returns 0.
- ALU writes never touch the scoreboard.
- Simultaneous push and pop: count unchanged, pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation discards FIFO contents and busy bits. Any in-flight output write is dropped (wena=0 next cycle).

Optional Feature:
- Macro: GYN_WB_BYPASS_EN.
- Defined: adds outputs q_r0fwd/q_r1fwd (1) and q_fwd_data (72, source 0) plus q_fwd1_data (72, source 1).
  - q_rNfwd=1 when wena[q_tid]=1 and waddr==q_rNaddr (nonzero); q_fwd*_data = wdata.
  - Decode may consume the value in the landing cycle instead of waiting one more cycle.
  - busy semantics are unchanged.
- Undefined: these ports are absent and no forwarding logic is built.

Test Plan:
- ALU only: alu_valid, tid=2, rd=5, data=72'hA5 -> next cycle wena=4'b0100, waddr=5, wdata=72'hA5; following cycle wena=0.
- Conflict: ALU (t0, r1, 1) and mem (t1, r3, 2) in the same cycle -> cycle+1 ALU write. The mem beat is buffered (fifo_cnt=1), so cycle+2 wena=4'b0010, waddr=3, wdata=2, fifo_cnt=0.
- Back-pressure: ALU held valid, 4 mem beats accepted -> fifo_cnt=4, mem_ready=0. Drop ALU -> the 4 loads drain in order one per cycle and mem_ready returns to 1.
- Scoreboard: ld_issue (t3, r7), query t3/r7 -> busy=1. Mem result (t3, r7) arrives -> busy=1 while wena is high and 0 the cycle after. An ld_issue to (t3, r7) in the wena cycle keeps busy=1.
- Zero/illegal addresses: ALU rd=0 -> wena stays 0, err_addr=0. Mem rd=9 -> wena stays 0, err_addr=1 and stays 1 until reset.
- Reset mid-drain: reset with fifo_cnt=3 and busy bits set -> next cycle fifo_cnt=0, all busy 0, wena=0.
